ksa_pipe: RTL and testbench
===========================

KSA_PIPE -- requirements
Module: ksa_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/sum width in bits; SHALL be a power of two, 2 to 64, else elaboration error.
REQ-002 Derived constant LVL = log2(WIDTH) prefix levels; LAT = LVL + 2 cycles latency; both SHALL be localparams, not overridable.
REQ-003 i_clk  input  1  sole clock, all state on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_valid  input  1  operand beat present.
REQ-006 o_in_ready  output  1  block accepts a beat this cycle.
REQ-007 i_a  input  WIDTH  operand A.
REQ-008 i_b  input  WIDTH  operand B.
REQ-009 i_cin  input  1  carry-in (add) / borrow-in (sub).
REQ-010 i_sub  input  1  0 = add, 1 = subtract.
REQ-011 o_valid  output  1  result beat present.
REQ-012 i_out_ready  input  1  downstream accepts result.
REQ-013 o_s  output  WIDTH  sum/difference.
REQ-014 o_carry  output  1  carry-out of MSB (sub: 1 = no borrow).
REQ-015 o_ovf  output  1  two's-complement signed overflow.
REQ-016 o_zero  output  1  o_s == 0.

Function
REQ-017 Effective operands: b_eff = i_sub ? ~i_b : i_b; c_eff = i_sub ? ~i_cin : i_cin; result = i_a + b_eff + c_eff, WIDTH+1 bits, MSB to o_carry.
REQ-018 Sub mode therefore yields i_a - i_b - i_cin mod 2^WIDTH.
REQ-019 o_ovf = (i_a[MSB] == b_eff[MSB]) && (o_s[MSB] != i_a[MSB]), computed per beat.
REQ-020 Structure: stage 0 registers bitwise p = a^b_eff, g = a&b_eff, c_eff, a/b_eff MSBs; stages 1..LVL each register one Kogge-Stone prefix level at distance 2^(k-1), carry-in folded as bit -1 generate; stage LVL+1 registers sum, carry, ovf, zero.
REQ-021 Each stage SHALL carry a valid bit; o_valid = valid bit of final stage.
REQ-022 Global advance: adv = !o_valid || i_out_ready; all stages load on adv, hold otherwise.
REQ-023 o_in_ready = adv; beat accepted when i_valid && o_in_ready.
REQ-024 Cycle with adv and no accepted beat SHALL insert a bubble (stage-0 valid = 0); bubbles are not collapsed.
REQ-025 Accepted beat SHALL appear on outputs exactly LAT advancing cycles later; with i_out_ready held 1, throughput one beat per cycle.
REQ-026 While o_valid && !i_out_ready, o_s/o_carry/o_ovf/o_zero and all stage contents SHALL remain stable.
REQ-027 Result ordering SHALL equal acceptance order; no beat dropped or duplicated.
REQ-028 i_sub and i_cin sampled with the beat; mode may change every beat.
REQ-029 o_s/flags are don't-care when o_valid = 0 but SHALL hold last loaded values (no X).

Reset
REQ-030 i_rst asserted SHALL immediately clear all stage valid bits and data registers; o_valid = 0, o_s = 0, o_carry = 0, o_ovf = 0, o_zero = 0.
REQ-031 During reset o_in_ready = 1 is permitted only after deassertion; o_in_ready SHALL be 0 while i_rst = 1.
REQ-032 Reset mid-operation SHALL discard all in-flight beats; first accepted beat after release emerges LAT cycles later.

Verification (WIDTH = 8, LAT = 5 unless noted)
REQ-033 Add 0xFF + 0x01, cin 0, i_out_ready 1 -> 5 cycles later o_valid 1, o_s 0x00, o_carry 1, o_zero 1, o_ovf 0.
REQ-034 Sub 0x80 - 0x01, cin 0 -> o_s 0x7F, o_carry 1, o_ovf 1; sub 0x00 - 0x01 -> o_s 0xFF, o_carry 0, o_ovf 0.
REQ-035 Back-to-back: 100 random beats alternating add/sub with i_out_ready 1 -> 100 results on consecutive cycles, matching reference model in order.
REQ-036 Backpressure: stream beats, drop i_out_ready for 7 cycles -> o_in_ready 0 during stall, outputs frozen, no loss/duplication after release.
REQ-037 Reset mid-stream: assert i_rst with 3 beats in flight -> o_valid 0 same cycle, none of the 3 ever emerges.
REQ-038 WIDTH = 32 and 64 random regression incl. cin/borrow corners 0, all-ones, 0x8000..0 -> exact match.

Source files
------------

// File: rtl/ksa_pipe.sv
// ksa_pipe: pipelined Kogge-Stone adder/subtractor with valid/ready flow control
module ksa_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_zero
);
  localparam int LVL = $clog2(WIDTH);
  localparam int LAT = LVL + 2;
  if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("ksa_pipe: WIDTH must be a power of two between 2 and 64");
  end
  // Prefix vectors are WIDTH+1 wide: bit 0 holds the carry-in as a generate
  // with zero propagate, bit i+1 holds operand bit i.
  logic [WIDTH:0]   g_q [0:LAT-2];
  logic [WIDTH:0]   p_q [0:LAT-2];
  logic [WIDTH:0]   g_d [0:LAT-2];
  logic [WIDTH:0]   p_d [0:LAT-2];
  logic [WIDTH-1:0] h_q [0:LAT-2];
  logic [1:0]       m_q [0:LAT-2];
  logic [LAT-2:0]   v_q;
  logic             vo_q, carry_q, ovf_q, zero_q;
  logic [WIDTH-1:0] s_q, s_d, b_eff;
  logic             c_eff, carry_d, ovf_d, zero_d, adv, acc;
  assign adv        = !vo_q || i_out_ready;
  assign o_in_ready = adv && !i_rst;
  assign acc        = i_valid && o_in_ready;
  assign b_eff      = i_sub ? ~i_b : i_b;
  assign c_eff      = i_sub ? ~i_cin : i_cin;
  assign g_d[0]     = {i_a & b_eff, c_eff};
  assign p_d[0]     = {i_a ^ b_eff, 1'b0};
  for (genvar k = 1; k <= LVL; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_op
        assign g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-D]);
        assign p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-D];
      end else begin : g_pass
        assign g_d[k][i] = g_q[k-1][i];
        assign p_d[k][i] = p_q[k-1][i];
      end
    end
  end
  // After the last level, bit i is the carry into operand bit i; the top
  // group excludes the carry-in, so fold it in with the group propagate.
  assign s_d     = h_q[LVL] ^ g_q[LVL][WIDTH-1:0];
  assign carry_d = g_q[LVL][WIDTH] | (p_q[LVL][WIDTH] & g_q[LVL][0]);
  assign ovf_d   = (m_q[LVL][1] == m_q[LVL][0]) && (s_d[WIDTH-1] != m_q[LVL][1]);
  assign zero_d  = ~|s_d;
  // Whole pipe advances together; data registers only load for valid beats so outputs hold across bubbles.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      v_q     <= '0;
      vo_q    <= 1'b0;
      s_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k <= LVL; k++) begin
        g_q[k] <= '0;
        p_q[k] <= '0;
        h_q[k] <= '0;
        m_q[k] <= '0;
      end
    end else if (adv) begin
      v_q  <= {v_q[LAT-3:0], acc};
      vo_q <= v_q[LAT-2];
      if (acc) begin
        g_q[0] <= g_d[0];
        p_q[0] <= p_d[0];
        h_q[0] <= i_a ^ b_eff;
        m_q[0] <= {i_a[WIDTH-1], b_eff[WIDTH-1]};
      end
      for (int k = 1; k <= LVL; k++)
        if (v_q[k-1]) begin
          g_q[k] <= g_d[k];
          p_q[k] <= p_d[k];
          h_q[k] <= h_q[k-1];
          m_q[k] <= m_q[k-1];
        end
      if (v_q[LAT-2]) begin
        s_q     <= s_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
        zero_q  <= zero_d;
      end
    end
  assign o_valid = vo_q;
  assign o_s     = s_q;
  assign o_carry = carry_q;
  assign o_ovf   = ovf_q;
  assign o_zero  = zero_q;
endmodule

// File: tb/tb_ksa_pipe.sv
// tb_ksa_pipe: randomized scoreboard bench for ksa_pipe at WIDTH 8, 32 and 64
module tb_ksa_pipe;
  logic clk = 1'b0;
  logic rst, vin, rdy, cin, sub;
  logic [63:0] a [3];
  logic [63:0] b [3];
  logic [7:0]  s8;
  logic [31:0] s32;
  logic [63:0] s64;
  logic [63:0] os [3];
  logic [2:0]  ir, ov, oc, oo, oz;
  int wd  [3] = '{8, 32, 64};
  int lat [3] = '{5, 7, 8};
  typedef struct {logic [66:0] e; int st;} ent_t;
  ent_t fifo [3][64];
  int wp [3] = '{0, 0, 0};
  int rp [3] = '{0, 0, 0};
  int ac [3] = '{0, 0, 0};
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  ksa_pipe #(.WIDTH(8)) u8 (.i_clk(clk), .i_rst(rst), .i_valid(vin), .o_in_ready(ir[0]),
    .i_a(a[0][7:0]), .i_b(b[0][7:0]), .i_cin(cin), .i_sub(sub), .o_valid(ov[0]),
    .i_out_ready(rdy), .o_s(s8), .o_carry(oc[0]), .o_ovf(oo[0]), .o_zero(oz[0]));
  ksa_pipe #(.WIDTH(32)) u32 (.i_clk(clk), .i_rst(rst), .i_valid(vin), .o_in_ready(ir[1]),
    .i_a(a[1][31:0]), .i_b(b[1][31:0]), .i_cin(cin), .i_sub(sub), .o_valid(ov[1]),
    .i_out_ready(rdy), .o_s(s32), .o_carry(oc[1]), .o_ovf(oo[1]), .o_zero(oz[1]));
  ksa_pipe #(.WIDTH(64)) u64 (.i_clk(clk), .i_rst(rst), .i_valid(vin), .o_in_ready(ir[2]),
    .i_a(a[2]), .i_b(b[2]), .i_cin(cin), .i_sub(sub), .o_valid(ov[2]),
    .i_out_ready(rdy), .o_s(s64), .o_carry(oc[2]), .o_ovf(oo[2]), .o_zero(oz[2]));
  always_comb begin
    os[0] = {56'b0, s8};
    os[1] = {32'b0, s32};
    os[2] = s64;
  end
  // Reference: {ovf, zero, carry, sum} from plain wide arithmetic.
  function automatic logic [66:0] model(int w, logic [63:0] x0, logic [63:0] y0, logic ci, logic sb);
    logic [127:0] m, x, y, r;
    logic [63:0] s;
    logic co, vf;
    m  = (128'd1 << w) - 128'd1;
    x  = {64'b0, x0} & m;
    y  = (sb ? ~{64'b0, y0} : {64'b0, y0}) & m;
    r  = x + y + {127'b0, sb ^ ci};
    s  = r[63:0] & m[63:0];
    co = r[w];
    vf = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    return {vf, s == 64'd0, co, s};
  endfunction
  function automatic logic [63:0] corner(int w);
    logic [63:0] m;
    m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return m;
      2: return 64'd1 << (w - 1);
      3: return 64'd1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction
  task automatic chk(string n, logic [69:0] act, logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic drive(logic v, logic s);
    vin = v;
    sub = s;
    cin = 1'($urandom);
    for (int d = 0; d < 3; d++) begin
      a[d] = corner(wd[d]);
      b[d] = corner(wd[d]);
    end
  endtask
  task automatic set_ops(logic [63:0] x, logic [63:0] y);
    for (int d = 0; d < 3; d++) begin
      a[d] = x;
      b[d] = y;
    end
  endtask
  // Scoreboard: every negedge, check handshake rule and result/latency of the head beat.
  always @(negedge clk)
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        chk($sformatf("rst_state%0d", wd[d]), {ov[d], ir[d], oc[d], oo[d], oz[d], os[d]}, '0);
        wp[d] = 0;
        rp[d] = 0;
      end else begin
        chk($sformatf("in_ready%0d", wd[d]), ir[d], !ov[d] || rdy);
        if (ov[d]) begin
          if (wp[d] == rp[d]) chk($sformatf("spurious%0d", wd[d]), ov[d], 1'b0);
          else begin
            chk($sformatf("result%0d", wd[d]), {oo[d], oz[d], oc[d], os[d]}, fifo[d][rp[d] % 64].e);
            if (rdy) begin
              chk($sformatf("latency%0d", wd[d]), ac[d] - fifo[d][rp[d] % 64].st, lat[d]);
              rp[d]++;
            end
          end
        end
        if (vin && ir[d]) begin
          fifo[d][wp[d] % 64] = '{model(wd[d], a[d], b[d], cin, sub), ac[d]};
          wp[d]++;
        end
        if (!ov[d] || rdy) ac[d]++;
      end
    end
  initial begin
    rst = 1'b1; vin = 1'b0; rdy = 1'b1; cin = 1'b0; sub = 1'b0;
    set_ops(64'd0, 64'd0);
    chk("pin_add8",  {3'b0, model(8, 64'hFF, 64'h01, 1'b0, 1'b0)}, {3'b0, 1'b0, 1'b1, 1'b1, 64'h0});
    chk("pin_sub8a", {3'b0, model(8, 64'h80, 64'h01, 1'b0, 1'b1)}, {3'b0, 1'b1, 1'b0, 1'b1, 64'h7F});
    chk("pin_sub8b", {3'b0, model(8, 64'h00, 64'h01, 1'b0, 1'b1)}, {3'b0, 1'b0, 1'b0, 1'b0, 64'hFF});
    chk("pin_sub64", {3'b0, model(64, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1)},
        {3'b0, 1'b1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF});
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    vin = 1'b1; sub = 1'b0; cin = 1'b0; set_ops(64'hFF, 64'h01);
    @(posedge clk); #1 sub = 1'b1; set_ops(64'h80, 64'h01);
    @(posedge clk); #1 set_ops(64'h00, 64'h01);
    @(posedge clk); #1 vin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) chk("lit_add",  {ov[0], oc[0], oo[0], oz[0], os[0][7:0]}, {4'b1101, 8'h00});
    @(negedge clk) chk("lit_sub1", {ov[0], oc[0], oo[0], oz[0], os[0][7:0]}, {4'b1110, 8'h7F});
    @(negedge clk) chk("lit_sub2", {ov[0], oc[0], oo[0], oz[0], os[0][7:0]}, {4'b1000, 8'hFF});
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1 drive(1'b1, 1'(i));
    end
    @(posedge clk); #1 vin = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1 drive(1'b1, 1'($urandom));
      rdy = !(i >= 10 && i < 17);
    end
    @(posedge clk); #1 vin = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1 drive($urandom_range(0, 3) != 0, 1'($urandom));
      rdy = $urandom_range(0, 3) != 0;
    end
    @(posedge clk); #1 vin = 1'b0; rdy = 1'b1;
    repeat (12) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 drive(1'b1, 1'(i));
    end
    @(posedge clk); #1 rst = 1'b1; vin = 1'b0;
    @(negedge clk) chk("rst_kill", ov, 3'b000);
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1 drive(1'b1, 1'b1);
    @(posedge clk); #1 vin = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("drained%0d", wd[d]), wp[d] - rp[d], 0);
    chk("post_rst_count8", wp[0], 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
